// File: rtl/cdc_hs_rx.sv
// Destination-side receiver for a toggle req/ack bundled-data CDC handshake.
// Synchronises the request toggle, captures the bundled word, and returns an ack toggle.
module cdc_hs_rx #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             test_mode,
  input  logic             req_tgl,
  input  logic [DW-1:0]    data_in,
  output logic             ack_tgl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             busy,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_s_q;
  logic                   req_seen;
  logic                   pending;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != req_seen);

  // Request toggle synchroniser; data_in is only ever sampled on acceptance.
  always_ff @(posedge dclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end
  end

  // Transfer FSM with registered outputs and violation tracking.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state     <= IDLE;
      req_s_q   <= 1'b0;
      req_seen  <= 1'b0;
      ack_tgl   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      viol      <= 1'b0;
      viol_cnt  <= '0;
    end else begin
      req_s_q <= req_s;
      case (state)
        IDLE: begin
          if (pending && !test_mode) begin
            state     <= HOLD;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= data_in;
            req_seen  <= req_s;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            ack_tgl   <= ~ack_tgl;
          end
          // Source toggled again before we acked: flag it, leave req_seen alone
          // so IDLE re-evaluates pending from the net toggle state.
          if (req_s != req_s_q) begin
            viol <= 1'b1;
            if (viol_cnt != {CNT_W{1'b1}}) begin
              viol_cnt <= viol_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
